// File: rtl/bj_pkg.sv
// Shared BlackJack constants, dealer state encoding and rank-to-points helpers
// for the card dealer and its hand accumulators.
package bj_pkg;

    localparam int RANK_ACE   = 1;
    localparam int RANK_TEN   = 10;
    localparam int RANK_KING  = 13;
    localparam int FACE_VALUE = 10;
    localparam int BJ_LIMIT   = 21;
    localparam int SOFT_BONUS = 10;
    localparam int HAND_W     = 6;
    localparam int RANK_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACCUM = 3'd3,
        ST_DONE  = 3'd4
    } dealer_state_t;

    // Ranks outside 1..13 are corrupt deck data.
    function automatic logic rank_is_bad(input logic [RANK_W-1:0] rank);
        return (rank == '0) || (rank > RANK_W'(RANK_KING));
    endfunction

    // Corrupt ranks still score as a ten so the hand stays plausible while o_Err flags it.
    function automatic logic [HAND_W-1:0] rank_points(input logic [RANK_W-1:0] rank);
        logic [HAND_W-1:0] pts;
        if (rank_is_bad(rank) || (rank > RANK_W'(RANK_TEN))) begin
            pts = HAND_W'(FACE_VALUE);
        end else begin
            pts = HAND_W'(rank);
        end
        return pts;
    endfunction

endpackage

// File: rtl/bj_hand_accum.sv
// One BlackJack hand: saturating hard sum plus an ace flag, resolved to a
// registered soft/hard value on every added card.
module bj_hand_accum
    import bj_pkg::*;
(
    input  logic              i_Clk,
    input  logic              i_Reset_n,
    input  logic              i_Clear,
    input  logic              i_Add,
    input  logic [RANK_W-1:0] i_Rank,
    output logic [HAND_W-1:0] o_Value
);
    localparam int SUM_W = HAND_W + 1;

    logic [HAND_W-1:0] r_hard;
    logic              r_has_ace;
    logic [HAND_W-1:0] r_value;

    logic [SUM_W-1:0]  w_sum;
    logic [HAND_W-1:0] w_hard_next;
    logic              w_ace_next;
    logic [SUM_W-1:0]  w_soft;
    logic [HAND_W-1:0] w_value_next;

    // The resolved value is computed from the post-add sum so it is already
    // final in the cycle after the add strobe.
    always_comb begin
        w_sum        = {1'b0, r_hard} + {1'b0, rank_points(i_Rank)};
        w_hard_next  = w_sum[HAND_W] ? '1 : w_sum[HAND_W-1:0];
        w_ace_next   = r_has_ace | (i_Rank == RANK_W'(RANK_ACE));
        w_soft       = {1'b0, w_hard_next} + SUM_W'(SOFT_BONUS);
        w_value_next = w_hard_next;
        if (w_ace_next && (w_soft <= SUM_W'(BJ_LIMIT))) begin
            w_value_next = w_soft[HAND_W-1:0];
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_hard    <= '0;
            r_has_ace <= 1'b0;
            r_value   <= '0;
        end else if (i_Clear) begin
            r_hard    <= '0;
            r_has_ace <= 1'b0;
            r_value   <= '0;
        end else if (i_Add) begin
            r_hard    <= w_hard_next;
            r_has_ace <= w_ace_next;
            r_value   <= w_value_next;
        end
    end

    assign o_Value = r_value;

endmodule

// File: rtl/card_dealer.sv
// Card dealer: on each controller request fetches the next rank from the
// shuffled deck RAM and folds it into the player or dealer hand.
module card_dealer
    import bj_pkg::*;
#(
    parameter int DECK_SIZE = 52,
    parameter int ADDR_W    = 6,
    parameter int RD_LAT    = 1
) (
    input  logic              i_Clk,
    input  logic              i_Reset_n,
    input  logic              i_NewGame,
    input  logic              i_Card2Player,
    input  logic              i_Card2Dealer,
    output logic              o_CardOK,
    output logic [HAND_W-1:0] o_HandP,
    output logic [HAND_W-1:0] o_HandD,
    output logic              o_DeckRd,
    output logic [ADDR_W-1:0] o_DeckAddr,
    input  logic [RANK_W-1:0] i_DeckData,
    output logic [RANK_W-1:0] o_LastCard,
    output logic              o_DeckEmpty,
    output logic              o_Err
);
    localparam int                CNT_W     = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'((RD_LAT > 1) ? (RD_LAT - 2) : 0);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DECK_SIZE - 1);

    dealer_state_t     r_state;
    dealer_state_t     w_next_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              r_to_dealer;
    logic [RANK_W-1:0] r_last_card;
    logic              r_deck_empty;
    logic              r_err;

    logic w_any_req;
    logic w_both_req;
    logic w_fetch;
    logic w_wait;
    logic w_accum;
    logic w_done;
    logic w_add_p;
    logic w_add_d;

    assign w_any_req  = i_Card2Player | i_Card2Dealer;
    assign w_both_req = i_Card2Player & i_Card2Dealer;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // New game overrides every transition, dropping any deal in flight.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_any_req) w_next_state = ST_FETCH;
            ST_FETCH: w_next_state = (RD_LAT == 1) ? ST_ACCUM : ST_WAIT;
            ST_WAIT:  if (r_wait_cnt == WAIT_LAST) w_next_state = ST_ACCUM;
            ST_ACCUM: w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
        if (i_NewGame) begin
            w_next_state = ST_IDLE;
        end
    end

    always_comb begin
        w_fetch = 1'b0;
        w_wait  = 1'b0;
        w_accum = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_FETCH: w_fetch = 1'b1;
            ST_WAIT:  w_wait  = 1'b1;
            ST_ACCUM: w_accum = 1'b1;
            ST_DONE:  w_done  = 1'b1;
            default:  ;
        endcase
    end

    assign w_add_p = w_accum & ~r_to_dealer;
    assign w_add_d = w_accum &  r_to_dealer;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_ptr        <= '0;
            r_wait_cnt   <= '0;
            r_to_dealer  <= 1'b0;
            r_last_card  <= '0;
            r_deck_empty <= 1'b0;
            r_err        <= 1'b0;
        end else if (i_NewGame) begin
            r_ptr        <= '0;
            r_wait_cnt   <= '0;
            r_to_dealer  <= 1'b0;
            r_last_card  <= '0;
            r_deck_empty <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // Target is frozen at IDLE; later request changes are ignored until DONE.
            if ((r_state == ST_IDLE) && w_any_req) begin
                r_to_dealer <= ~i_Card2Player;
            end
            if ((r_state == ST_IDLE) && w_both_req) begin
                r_err <= 1'b1;
            end
            if (w_fetch) begin
                r_wait_cnt <= '0;
            end else if (w_wait) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end
            if (w_accum) begin
                r_last_card <= i_DeckData;
                if (rank_is_bad(i_DeckData)) begin
                    r_err <= 1'b1;
                end
                // Running off the end of the deck is reported but dealing carries on.
                if (r_ptr == LAST_ADDR) begin
                    r_ptr        <= '0;
                    r_deck_empty <= 1'b1;
                end else begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                end
            end
        end
    end

    bj_hand_accum u_hand_p (
        .i_Clk     (i_Clk),
        .i_Reset_n (i_Reset_n),
        .i_Clear   (i_NewGame),
        .i_Add     (w_add_p),
        .i_Rank    (i_DeckData),
        .o_Value   (o_HandP)
    );

    bj_hand_accum u_hand_d (
        .i_Clk     (i_Clk),
        .i_Reset_n (i_Reset_n),
        .i_Clear   (i_NewGame),
        .i_Add     (w_add_d),
        .i_Rank    (i_DeckData),
        .o_Value   (o_HandD)
    );

    assign o_CardOK    = w_done;
    assign o_DeckRd    = w_fetch;
    assign o_DeckAddr  = r_ptr;
    assign o_LastCard  = r_last_card;
    assign o_DeckEmpty = r_deck_empty;
    assign o_Err       = r_err;

endmodule
